tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen_pkg.sv | 15 +
 rtl/tick_div_stage.sv | 92 +++++++++
 rtl/tick_gen.sv | 87 ++++++++
 tb/tb_tick_gen.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared defaults and helpers for the tick_gen prescaler / cascaded divider block.
package tick_gen_pkg;

  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned NUM_CH_DEF = 4;

  // Channel 0 in the LSBs: ch0=10, ch1=2, ch2=50, ch3=2.
  localparam logic [NUM_CH_DEF*CNT_W_DEF-1:0] DIV_INIT_DEF = {8'd2, 8'd50, 8'd2, 8'd10};

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/tick_div_stage.sv
// One divider channel: pulse counter, pending/active divisor, tick and optional level flop.
// Level toggle flop is only built when TICK_GEN_LEVEL_EN is defined.
module tick_div_stage
  import tick_gen_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             pulse_i,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_data_i,
  output logic             tick_o,
  output logic             level_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             wrap_c;

  // Divisors 0 and 1 both pass every input pulse through.
  assign wrap_c = (act_q <= CNT_W'(1)) || (cnt_q == act_q - CNT_W'(1));

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    tick_d = 1'b0;
    if (wr_en_i) begin
      pend_d = wr_data_i;
    end
    // A write in the reload clk is picked up through pend_d.
    if (clr_i) begin
      cnt_d = '0;
      act_d = pend_d;
    end else if (pulse_i) begin
      if (wrap_c) begin
        cnt_d  = '0;
        act_d  = pend_d;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      act_q  <= DIV_RST;
      pend_q <= DIV_RST;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

`ifdef TICK_GEN_LEVEL_EN
  logic level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (clr_i) begin
      level_d = 1'b0;
    end else if (tick_d) begin
      level_d = ~level_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
`else
  assign level_o = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// Prescaler followed by NUM_CH cascaded divider channels producing one-clk ticks.
// Define TICK_GEN_LEVEL_EN to build the per-channel 50% level outputs; otherwise level is 0.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned              IN_FREQ   = 1000000,
  parameter int unsigned              BASE_FREQ = 2000,
  parameter int unsigned              NUM_CH    = 4,
  parameter int unsigned              CNT_W     = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_INIT  = (NUM_CH*CNT_W)'(DIV_INIT_DEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          clear,
  input  logic                       div_wr,
  input  logic [sel_w(NUM_CH)-1:0]   div_sel,
  input  logic [CNT_W-1:0]           div_data,
  output logic                       tick_base,
  output logic [NUM_CH-1:0]          tick,
  output logic [NUM_CH-1:0]          level
);

  localparam int unsigned SEL_W = sel_w(NUM_CH);
  localparam int unsigned PRE   = (IN_FREQ / BASE_FREQ > 0) ? IN_FREQ / BASE_FREQ : 1;
  localparam int unsigned PRE_W = sel_w(PRE);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick_base_q, tick_base_d;
  logic [NUM_CH-1:0] clr_eff_c;

  // Prescaler: one base pulse per PRE clks, raised in the clk after the terminal count.
  always_comb begin
    pre_d       = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
    tick_base_d = (pre_q == PRE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q       <= '0;
      tick_base_q <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      tick_base_q <= tick_base_d;
    end
  end

  assign tick_base = tick_base_q;

  // A clear on channel i also restarts every downstream channel.
  always_comb begin
    clr_eff_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      for (int j = 0; j <= i; j++) begin
        clr_eff_c[i] = clr_eff_c[i] | clear[j];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    logic pulse_c;
    logic wr_en_c;

    if (g == 0) begin : g_first
      assign pulse_c = tick_base_q;
    end else begin : g_next
      assign pulse_c = tick[g-1];
    end

    assign wr_en_c = div_wr && (div_sel == SEL_W'(g));

    tick_div_stage #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr_eff_c[g]),
      .pulse_i   (pulse_c),
      .wr_en_i   (wr_en_c),
      .wr_data_i (div_data),
      .tick_o    (tick[g]),
      .level_o   (level[g])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen with IN_FREQ=20, BASE_FREQ=2 (PRE=10), other parameters default.
module tb_tick_gen;

  localparam int NUM_CH = 4;
  localparam int PRE    = 10;
  localparam int DIVS [4] = '{10, 2, 50, 2};
`ifdef TICK_GEN_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] clear;
  logic       div_wr;
  logic [1:0] div_sel;
  logic [7:0] div_data;
  logic       tick_base;
  logic [3:0] tick;
  logic [3:0] level;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: prescaler as arithmetic on elapsed clks, channels as pulse tallies.
  int         m_n;
  logic       m_tb;
  logic [3:0] m_tick;
  logic [3:0] m_level;
  int         m_seen [4];
  int         m_act  [4];
  int         m_pend [4];

  int   ev_b [$];
  int   ev_t [4][$];
  int   ev_l0 [$];
  logic prev_l0 = 1'b0;

  tick_gen #(
    .IN_FREQ   (20),
    .BASE_FREQ (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .div_wr    (div_wr),
    .div_sel   (div_sel),
    .div_data  (div_data),
    .tick_base (tick_base),
    .tick      (tick),
    .level     (level)
  );

  always #5 clk = ~clk;

  function automatic void model_step();
    logic [3:0] in_p;
    logic       clr;
    int         eff;
    if (rst) begin
      m_n = 0;
      m_tb = 1'b0;
      m_tick = '0;
      m_level = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_seen[i] = 0;
        m_act[i]  = DIVS[i];
        m_pend[i] = DIVS[i];
      end
      return;
    end
    in_p = {m_tick[2:0], m_tb};
    m_n++;
    m_tb = (m_n % PRE == 0);
    clr = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      clr = clr | clear[i];
      if (div_wr && int'(div_sel) == i) m_pend[i] = int'(div_data);
      m_tick[i] = 1'b0;
      if (clr) begin
        m_seen[i]  = 0;
        m_act[i]   = m_pend[i];
        m_level[i] = 1'b0;
      end else if (in_p[i]) begin
        eff = (m_act[i] < 2) ? 1 : m_act[i];
        m_seen[i]++;
        if (m_seen[i] >= eff) begin
          m_seen[i] = 0;
          m_act[i]  = m_pend[i];
          m_tick[i] = 1'b1;
          if (LVL) m_level[i] = ~m_level[i];
        end
      end
    end
  endfunction

  task automatic step_clk();
    @(posedge clk);
    model_step();
    #1;
    if (rst) cyc = 0; else cyc++;
    if (tick_base) ev_b.push_back(cyc);
    for (int i = 0; i < NUM_CH; i++) if (tick[i]) ev_t[i].push_back(cyc);
    if (level[0] !== prev_l0) ev_l0.push_back(cyc);
    prev_l0 = level[0];
  endtask

  task automatic clear_ev();
    ev_b.delete();
    ev_l0.delete();
    for (int i = 0; i < NUM_CH; i++) ev_t[i].delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    clear_ev();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step_clk();
  endtask

  function automatic int qget(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({tick_base, tick, level} !== 9'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 0", {tick_base, tick, level});
    end
    run_to(55);
    div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd3;
    step_clk();
    div_wr = 1'b0;
    rst = 1'b1;
    step_clk();
    n_vec++;
    if ({tick_base, tick, level} !== 9'b0) begin
      n_err++; $display("FAIL midreset_outputs: got %b expected 0", {tick_base, tick, level});
    end
    rst = 1'b0;
    clear_ev();
    run_to(3);
    clear = 4'b0001;
    step_clk();
    clear = 4'b0000;
    run_to(120);
    n_vec++;
    if (qget(ev_b, 0) !== 10) begin
      n_err++; $display("FAIL restart_tick_base: got %0d expected 10", qget(ev_b, 0));
    end
    n_vec++;
    if (qget(ev_t[0], 0) !== 101) begin
      n_err++; $display("FAIL pending_reset_div: got %0d expected 101", qget(ev_t[0], 0));
    end
  endtask

  task automatic test_cadence();
    do_reset();
    run_to(250);
    n_vec++;
    if (qget(ev_b, 0) !== 10 || qget(ev_b, 1) !== 20 || qget(ev_b, 2) !== 30) begin
      n_err++; $display("FAIL base_cadence: got %0d,%0d,%0d expected 10,20,30",
                        qget(ev_b, 0), qget(ev_b, 1), qget(ev_b, 2));
    end
    n_vec++;
    if (qget(ev_t[0], 0) !== 101 || qget(ev_t[0], 1) !== 201) begin
      n_err++; $display("FAIL tick0_cadence: got %0d,%0d expected 101,201",
                        qget(ev_t[0], 0), qget(ev_t[0], 1));
    end
    n_vec++;
    if (qget(ev_t[1], 0) !== 202 || ev_t[2].size() !== 0) begin
      n_err++; $display("FAIL tick1_first: got %0d (ch2 count %0d) expected 202 (0)",
                        qget(ev_t[1], 0), ev_t[2].size());
    end
    n_vec++;
    if (qget(ev_l0, 0) !== (LVL ? 101 : -1) || qget(ev_l0, 1) !== (LVL ? 201 : -1)) begin
      n_err++; $display("FAIL level0_toggle: got %0d,%0d expected %0d,%0d",
                        qget(ev_l0, 0), qget(ev_l0, 1), LVL ? 101 : -1, LVL ? 201 : -1);
    end
    n_vec++;
    if (level !== m_level) begin
      n_err++; $display("FAIL level_state: got %b expected %b", level, m_level);
    end
  endtask

  task automatic test_div_write();
    div_wr = 1'b1; div_sel = 2'd1; div_data = 8'd3;
    step_clk();
    div_wr = 1'b0;
    run_to(1010);
    n_vec++;
    if (qget(ev_t[1], 1) !== 402 || qget(ev_t[1], 2) !== 702 || qget(ev_t[1], 3) !== 1002) begin
      n_err++; $display("FAIL div_write_ch1: got %0d,%0d,%0d expected 402,702,1002",
                        qget(ev_t[1], 1), qget(ev_t[1], 2), qget(ev_t[1], 3));
    end
    n_vec++;
    if (qget(ev_t[0], 9) !== 1001) begin
      n_err++; $display("FAIL div_write_ch0_cadence: got %0d expected 1001", qget(ev_t[0], 9));
    end
  endtask

  task automatic test_clear();
    do_reset();
    run_to(450);
    clear = 4'b0100;
    step_clk();
    clear = 4'b0000;
    n_vec++;
    if (tick[3:2] !== 2'b00 || level[3:2] !== 2'b00) begin
      n_err++; $display("FAIL clear2_outputs: got tick %b level %b expected 00 00", tick[3:2], level[3:2]);
    end
    run_to(10500);
    n_vec++;
    if (qget(ev_t[2], 0) !== 10403) begin
      n_err++; $display("FAIL clear2_next_tick: got %0d expected 10403", qget(ev_t[2], 0));
    end
    n_vec++;
    if (ev_t[0].size() !== 104 || qget(ev_t[0], 4) !== 501 || qget(ev_t[1], 2) !== 602) begin
      n_err++; $display("FAIL clear2_upstream: got n0=%0d t0=%0d t1=%0d expected 104,501,602",
                        ev_t[0].size(), qget(ev_t[0], 4), qget(ev_t[1], 2));
    end
  endtask

  task automatic test_clear_wrap();
    do_reset();
    run_to(100);
    n_vec++;
    if (tick_base !== 1'b1) begin
      n_err++; $display("FAIL wrap_base_present: got %b expected 1", tick_base);
    end
    clear = 4'b0001;
    step_clk();
    clear = 4'b0000;
    n_vec++;
    if (tick !== 4'b0000) begin
      n_err++; $display("FAIL clear_beats_pulse: got %b expected 0000", tick);
    end
    run_to(320);
    n_vec++;
    if (qget(ev_t[0], 0) !== 201 || qget(ev_t[1], 0) !== 302) begin
      n_err++; $display("FAIL clear_wrap_restart: got %0d,%0d expected 201,302",
                        qget(ev_t[0], 0), qget(ev_t[1], 0));
    end
  endtask

  task automatic test_passthrough();
    do_reset();
    run_to(4);
    div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd0;
    step_clk();
    div_wr = 1'b0;
    clear = 4'b0001;
    step_clk();
    clear = 4'b0000;
    run_to(60);
    n_vec++;
    if (ev_t[0].size() !== 5 || qget(ev_t[0], 0) !== 11 || qget(ev_t[0], 2) !== 31) begin
      n_err++; $display("FAIL passthrough_ch0: got n=%0d first=%0d third=%0d expected 5,11,31",
                        ev_t[0].size(), qget(ev_t[0], 0), qget(ev_t[0], 2));
    end
    n_vec++;
    if (qget(ev_t[1], 0) !== 22) begin
      n_err++; $display("FAIL passthrough_ch1: got %0d expected 22", qget(ev_t[1], 0));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 599) == 0);
      div_wr   = ($urandom_range(0, 7) == 0);
      div_sel  = 2'($urandom_range(0, 3));
      div_data = 8'($urandom_range(0, 4));
      clear    = ($urandom_range(0, 49) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      step_clk();
      n_vec++;
      if (tick_base !== m_tb) begin
        n_err++; $display("FAIL rand_tick_base @%0d: got %b expected %b", k, tick_base, m_tb);
      end
      n_vec++;
      if (tick !== m_tick) begin
        n_err++; $display("FAIL rand_tick @%0d: got %b expected %b", k, tick, m_tick);
      end
      n_vec++;
      if (level !== m_level) begin
        n_err++; $display("FAIL rand_level @%0d: got %b expected %b", k, level, m_level);
      end
    end
    rst = 1'b0; div_wr = 1'b0; clear = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; clear = 4'b0000; div_wr = 1'b0; div_sel = 2'd0; div_data = 8'd0;
    test_reset();
    test_cadence();
    test_div_write();
    test_clear();
    test_clear_wrap();
    test_passthrough();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
